// File: rtl/pipe_stage_pkg.sv
// Shared types for the inter-stage pipeline register: occupancy states and helpers.
package pipe_stage_pkg;

  // Number of payloads currently held by a stage. TWO only exists with the skid entry.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  // Deepest occupancy a stage can reach for a given skid setting.
  function automatic occ_state_e occ_limit(input int skid);
    return (skid != 0) ? OCC_TWO : OCC_ONE;
  endfunction

  // A stage still has room for another payload unless both entries are full.
  function automatic logic has_room(input occ_state_e occ);
    return (occ != OCC_TWO);
  endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One storage slot of a pipeline stage: a payload register and its valid bit.
// Flush clears only the valid bit so squashed stages do not toggle the data bus.
module pipe_stage_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  // Reset beats flush, flush beats load, and a load wins over a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register between two CPU stages, with synchronous flush.
// SKID=0 keeps one entry and a combinational ready; SKID=1 adds a second entry so
// the ready output comes straight from a flop and the allow-in chain is broken.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occ_o
);

  occ_state_e       occ;
  occ_state_e       occ_next;
  logic             in_ready_q;
  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic             main_clear;
  logic             main_valid;
  logic [WIDTH-1:0] main_src;
  logic             skid_load;
  logic             skid_clear;

  // Without skid, ready is simply "main is free or being drained this cycle";
  // with skid it is the registered room flag, so no input reaches it combinationally.
  assign in_ready_o  = (SKID != 0) ? in_ready_q
                                   : (rst_i && (!main_valid || out_ready_i));
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = main_valid && out_ready_i;
  assign out_valid_o = main_valid;
  assign occ_o       = occ;

  // Decide the next occupancy and what the main entry does this edge.
  always_comb begin
    occ_next   = occ;
    main_load  = 1'b0;
    main_clear = 1'b0;
    case (occ)
      OCC_EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          occ_next  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (out_fire) begin
          main_clear = 1'b1;
          occ_next   = OCC_EMPTY;
        end else if (in_fire && (occ_limit(SKID) == OCC_TWO)) begin
          occ_next = OCC_TWO;
        end
      end
      OCC_TWO: begin
        if (out_fire) begin
          main_load = 1'b1;
          occ_next  = OCC_ONE;
        end
      end
      default: begin
        occ_next = OCC_EMPTY;
      end
    endcase
    if (flush_i) begin
      occ_next = OCC_EMPTY;
    end
  end

  // Occupancy state and the registered allow-in flag; ready stays low through reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      occ        <= OCC_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      occ        <= occ_next;
      in_ready_q <= has_room(occ_next);
    end
  end

  pipe_stage_entry #(
    .WIDTH(WIDTH)
  ) u_main (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(flush_i),
    .load_i (main_load),
    .clear_i(main_clear),
    .data_i (main_src),
    .valid_o(main_valid),
    .data_o (out_data_o)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic             skid_valid;
      logic [WIDTH-1:0] skid_data;

      // The skid slot catches the one payload accepted while main is stalled and
      // hands it to main when main drains, so ordering stays first-in first-out.
      assign skid_load  = (occ == OCC_ONE) && in_fire && !out_fire;
      assign skid_clear = (occ == OCC_TWO) && out_fire;
      assign main_src   = skid_valid ? skid_data : in_data_i;

      pipe_stage_entry #(
        .WIDTH(WIDTH)
      ) u_skid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .flush_i(flush_i),
        .load_i (skid_load),
        .clear_i(skid_clear),
        .data_i (in_data_i),
        .valid_o(skid_valid),
        .data_o (skid_data)
      );
    end else begin : g_no_skid
      assign skid_load  = 1'b0;
      assign skid_clear = 1'b0;
      assign main_src   = in_data_i;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench: runs a SKID=0 and a SKID=1 stage side by side against a
// FIFO-of-capacity reference model, with directed phases then randomized traffic.
module tb_pipe_stage;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         flush;
  logic         in_valid  [2];
  logic [W-1:0] in_data   [2];
  logic         in_ready  [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [W-1:0] out_data  [2];
  logic [1:0]   occ       [2];

  // Reference model: per lane a FIFO holding up to 1 (SKID=0) or 2 (SKID=1) payloads.
  int           cnt       [2];
  logic [W-1:0] fifo      [2][2];
  logic [W-1:0] last_head [2];
  logic         rdy_reg   [2];
  logic         exp_valid [2];
  logic         exp_ready [2];
  logic [W-1:0] exp_data  [2];

  // Upstream producers: a ring of pending payloads per lane.
  logic [W-1:0] src    [2][64];
  int           src_rd [2];
  int           src_wr [2];
  logic         gate   [2];

  int checks = 0;
  int errors = 0;

  pipe_stage #(.WIDTH(W), .SKID(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
    .occ_o(occ[0])
  );

  pipe_stage #(.WIDTH(W), .SKID(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
    .occ_o(occ[1])
  );

  task automatic push(input int l, input logic [W-1:0] d);
    src[l][src_wr[l] % 64] = d;
    src_wr[l]++;
  endtask

  task automatic push_both(input logic [W-1:0] d);
    push(0, d);
    push(1, d);
  endtask

  // Offer the head of each producer ring, or a toggling junk word on bubbles.
  task automatic apply_stimulus();
    for (int l = 0; l < 2; l++) begin
      if ((src_rd[l] < src_wr[l]) && gate[l]) begin
        in_valid[l] = 1'b1;
        in_data[l]  = src[l][src_rd[l] % 64];
      end else begin
        in_valid[l] = 1'b0;
        in_data[l]  = $urandom;
      end
    end
  endtask

  task automatic check_output(input int l);
    exp_valid[l] = (cnt[l] > 0);
    exp_data[l]  = (cnt[l] > 0) ? fifo[l][0] : last_head[l];
    exp_ready[l] = (l == 0) ? (rst && ((cnt[l] == 0) || out_ready[l])) : rdy_reg[l];
    checks++;
    assert (out_valid[l] === exp_valid[l]) else begin
      errors++;
      $error("[TB] FAIL lane%0d out_valid got %0b want %0b", l, out_valid[l], exp_valid[l]);
    end
    checks++;
    assert (out_data[l] === exp_data[l]) else begin
      errors++;
      $error("[TB] FAIL lane%0d out_data got %h want %h", l, out_data[l], exp_data[l]);
    end
    checks++;
    assert (in_ready[l] === exp_ready[l]) else begin
      errors++;
      $error("[TB] FAIL lane%0d in_ready got %0b want %0b", l, in_ready[l], exp_ready[l]);
    end
    checks++;
    assert (occ[l] === 2'(cnt[l])) else begin
      errors++;
      $error("[TB] FAIL lane%0d occ got %0d want %0d", l, occ[l], cnt[l]);
    end
  endtask

  task automatic update_model(input int l);
    logic in_take;
    logic out_take;
    if (!rst) begin
      cnt[l]       = 0;
      last_head[l] = '0;
      rdy_reg[l]   = 1'b0;
    end else begin
      in_take  = in_valid[l] && exp_ready[l];
      out_take = exp_valid[l] && out_ready[l];
      if (in_take) src_rd[l]++;
      if (flush) begin
        cnt[l] = 0;
      end else begin
        if (out_take) begin
          fifo[l][0] = fifo[l][1];
          cnt[l]--;
        end
        if (in_take) begin
          fifo[l][cnt[l]] = in_data[l];
          cnt[l]++;
        end
      end
      rdy_reg[l] = (cnt[l] < 2);
      if (cnt[l] > 0) last_head[l] = fifo[l][0];
    end
  endtask

  task automatic cycle();
    apply_stimulus();
    @(negedge clk);
    check_output(0);
    check_output(1);
    @(posedge clk);
    update_model(0);
    update_model(1);
    #1;
  endtask

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    for (int l = 0; l < 2; l++) begin
      in_valid[l]  = 1'b0;
      in_data[l]   = '0;
      out_ready[l] = 1'b1;
      gate[l]      = 1'b1;
      src_rd[l]    = 0;
      src_wr[l]    = 0;
      cnt[l]       = 0;
      last_head[l] = '0;
      rdy_reg[l]   = 1'b0;
      fifo[l][0]   = '0;
      fifo[l][1]   = '0;
    end

    // Reset held with a valid payload offered; it must wait until release.
    push_both(32'hDEADBEEF);
    apply_stimulus();
    @(posedge clk);
    #1;
    repeat (3) cycle();
    rst = 1'b1;

    // Back-to-back streaming with the downstream always ready.
    for (int i = 1; i <= 8; i++) push_both(W'(i));
    repeat (12) cycle();

    // Bubbles: no valid input, data bus toggling.
    repeat (4) cycle();

    // Backpressure with three payloads queued upstream.
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    push_both(32'hA);
    push_both(32'hB);
    push_both(32'hC);
    repeat (4) cycle();
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    repeat (5) cycle();

    // Hold a payload while stalled, second one waits.
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    push_both(32'h5);
    push_both(32'h6);
    repeat (3) cycle();
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    repeat (4) cycle();

    // Flush at full occupancy while 0x77 is being offered; 0x77 is then withdrawn.
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    push_both(32'hD);
    push_both(32'hE);
    push_both(32'h77);
    repeat (3) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int l = 0; l < 2; l++) src_rd[l] = src_wr[l];
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    repeat (3) cycle();

    // Flush on an edge where 0x77 is actually accepted: it must be dropped.
    push_both(32'h77);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (3) cycle();

    // Randomized traffic with random stalls, bubbles and occasional flushes.
    repeat (400) begin
      for (int l = 0; l < 2; l++) begin
        gate[l]      = (($urandom % 4) != 0);
        out_ready[l] = (($urandom % 3) != 0);
        if ((src_wr[l] - src_rd[l]) < 3) push(l, $urandom);
      end
      flush = (($urandom % 20) == 0);
      cycle();
    end

    // Drain.
    flush = 1'b0;
    for (int l = 0; l < 2; l++) begin
      gate[l]      = 1'b1;
      out_ready[l] = 1'b1;
    end
    repeat (10) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised inter-stage pipeline register that replaces the fixed-width, single-entry stage latches between IF/ID/EX/MEM/WB. It carries one `*BusSize`-wide payload with a valid/ready handshake (`*_over` → valid, `*_allow_in` → ready), adds synchronous flush for branch/exception squash, and optionally adds a 2-entry skid mode that registers the ready path to break the combinational allow-in chain across the whole pipeline.

## Interface
- `WIDTH`, 32: payload width in bits (instantiated with the bus-size constants from `common.vh`, e.g. `` `EX2MEMBusSize ``).
- `SKID`, 0: 0 = single entry with combinational `in_ready_o`; 1 = two entries with registered `in_ready_o`.
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_i`  in  1  synchronous, active-low reset.
- `flush_i`  in  1  squash all held entries this cycle.
- `in_valid_i`  in  1  upstream stage over (payload valid).
- `in_ready_o`  out  1  this stage allows in.
- `in_data_i`  in  WIDTH  upstream payload.
- `out_valid_o`  out  1  payload held for downstream.
- `out_ready_i`  in  1  downstream allows in.
- `out_data_o`  out  WIDTH  held payload (registered).
- `occ_o`  out  2  entries held (0..1 for SKID=0, 0..2 for SKID=1).

## Operation
- Input transfer: `in_valid_i && in_ready_o` at the edge. Output transfer: `out_valid_o && out_ready_i`.
- Reset (`rst_i`=0 at edge): all valid bits and all data registers ← 0, `occ_o` ← 0. While `rst_i`=0, `in_ready_o` is forced to 0 in both modes.
- Priority per edge: reset > flush > transfers.
- Flush: all valid bits ← 0, `occ_o` ← 0; data registers keep their values; any same-cycle input transfer is discarded (upstream sees `in_ready_o` unaffected by `flush_i`, but the payload is dropped).
- SKID=0:
  - `in_ready_o` = `!out_valid_o || out_ready_i` (combinational).
  - On edge with `in_ready_o`=1: `out_valid_o` ← `in_valid_i`; data ← `in_data_i` only when `in_valid_i`=1 (no data toggling on bubbles).
  - With `in_ready_o`=0: hold.
- SKID=1: main register (drives `out_*`) plus skid register.
  - `in_ready_o` is a flop equal to `occ < 2` (next-state value); it is 1 out of reset.
  - occ 0: input → main.
  - occ 1: output-only → occ 0. Input-only → skid (occ 2). Both → main ← input (occ 1).
  - occ 2: output → main ← skid, skid empty (occ 1). No input accepted (`in_ready_o`=0).
  - Order is strictly FIFO; the skid register never drives `out_data_o` directly.
- No payload is duplicated or lost except via flush/reset.

## Timing
- Latency: 1 cycle, input edge → `out_valid_o` high, both modes.
- Throughput: 1 transfer/cycle when `out_ready_i` is held at 1.
- SKID=0: `in_ready_o` has a combinational path from `out_ready_i`. SKID=1: no combinational input→output path on any port.
- SKID=1: after `out_ready_i` falls, up to one further input is accepted (absorbed by skid). `in_ready_o` falls on the next edge. After `out_ready_i` rises at occ 2, `in_ready_o` rises one edge later.
- After reset release, the first transfer is possible on the first edge with `rst_i`=1 (SKID=0) or the second edge (SKID=1, `in_ready_o` flop).

## Structure
- `common.vh` owns the bus-size macros (`IF2IDBusSize` … `MEM2WBBusSize`) and a `PIPE_SKID_DEFAULT` constant. Per-stage wrappers instantiate `pipe_stage` with `WIDTH` = the bus size.
- One sub-module: `pipe_stage_entry`, a WIDTH-wide data flop plus valid flop with load/clear/flush inputs. It is instantiated once for main and once for skid (skid instance gated by `generate` on SKID).
- Control is a 2-bit occupancy state machine (states EMPTY, ONE, TWO; TWO unreachable when SKID=0).

## Test plan
- Reset: hold `rst_i`=0 with `in_valid_i`=1 and data=0xDEADBEEF for 3 cycles → `out_valid_o`=0, `out_data_o`=0, `in_ready_o`=0, `occ_o`=0. Release → first transfer appears on the next cycle.
- Streaming (both modes): `out_ready_i`=1, send 0x1..0x8 back-to-back → `out_data_o` = 0x1..0x8 on 8 consecutive cycles, each 1 cycle after input, no gaps.
- Backpressure SKID=1: send 0xA, 0xB, 0xC with `out_ready_i`=0 → 0xA, 0xB accepted, `occ_o`=2, `in_ready_o`=0, 0xC held upstream. Raise `out_ready_i` → output order 0xA, 0xB, 0xC.
- Backpressure SKID=0: `out_ready_i`=0 while holding 0x5 → `in_ready_o`=0 the same cycle, `out_data_o` stays 0x5, and a second payload 0x6 is not taken until `out_ready_i`=1.
- Flush at occ 2 with a simultaneous input 0x77 → next cycle `out_valid_o`=0, `occ_o`=0. 0x77 is never output, and SKID=1 `in_ready_o`=1.
- Bubble: `in_valid_i`=0 with data toggling and `out_ready_i`=1 → `out_valid_o`=0 and `out_data_o` is unchanged from the last valid payload.
